spi_rom_responder: RTL
======================

Name: spi_rom_responder

Overview:
Synthesizable SPI flash-ROM responder: the device end of the READ (03h) link that our VGA SPI-ROM master drives. It oversamples SCLK/CS/MOSI in its own clock domain, decodes an 8-bit command and a 24-bit address, then streams bytes MSB-first on MISO from a synchronous byte-wide memory port, auto-incrementing the address. It serves as the FPGA/bench stand-in for the external flash so the master and its display path can be exercised end to end.

Parameters:
MEM_AW, 24, memory address width; low MEM_AW bits of the 24-bit SPI address drive mem_addr, upper bits ignored
SYNC_STAGES, 2, synchronizer depth on spi_cs, spi_sclk and spi_mosi (min 2)
CS_ACTIVE_HIGH, 1, 1: chip selected when spi_cs=1 (master convention); 0: active-low select

Ports:
clk  in  1  responder clock; must be ≥ 2*(SYNC_STAGES+3) × SCLK frequency
reset_n  in  1  asynchronous, active-low reset
spi_cs  in  1  chip select, polarity per CS_ACTIVE_HIGH
spi_sclk  in  1  SPI clock, mode 0 (idle low, sample on rise, shift on fall)
spi_mosi  in  1  command/address bits, MSB first
spi_miso  out  1  data bits, MSB first; 0 whenever not in DATA
spi_miso_oe  out  1  1 only while selected and in DATA
mem_rd  out  1  one-cycle read strobe
mem_addr  out  MEM_AW  read address, valid with mem_rd
mem_data  in  8  read data, valid exactly 1 clk after mem_rd
busy  out  1  1 while selected (after sync)
cmd_err  out  1  one-cycle pulse when a non-03h command byte completes

Behaviour:
- Reset (reset_n=0, async): state IDLE; spi_miso=0, spi_miso_oe=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0; shift/prefetch regs, bit counter, synchronizers cleared.
- All inputs pass SYNC_STAGES flops; edge detect on synced SCLK (rise/fall), synced select level. No logic uses raw inputs.
- Deselect (synced) in any state: next clk -> IDLE, miso=0, oe=0, counters cleared; a pending mem read result is discarded. Takes priority over any simultaneous SCLK edge.
- States: IDLE -> CMD on select. CMD: shift MOSI on each rise, bit_cnt 0..7; after 8th rise: byte==03h -> ADDR, else IGNORE with cmd_err pulse. ADDR: shift 24 bits on rises; on 24th rise assert mem_rd with mem_addr = addr[MEM_AW-1:0] in the same clk, -> DATA. IGNORE: no mem_rd, miso=0, until deselect.
- DATA: mem_data captured into prefetch 1 clk after mem_rd. On each SCLK fall: if bit_cnt==0 load shift reg from prefetch and drive bit 7, else shift left; miso registered, updates 1 clk after fall detection. After loading a byte, increment address (mod 2^MEM_AW, wrap to 0) and issue next mem_rd immediately, so prefetch is ready ≥7 SCLK periods ahead.
- First data bit appears after the fall following the 32nd rise (ADDR[0]); master samples it on the 33rd rise. Latency from pin fall to miso change: SYNC_STAGES+1 clk.
- SCLK rises in DATA ignore MOSI. Stream length unbounded; ends only on deselect.
- busy = synced select level, registered.

Decomposition:
- Shared package/header: SPI_CMD_READ=8'h03, SPI_CMD_LEN=8, SPI_ADDR_LEN=24 (also used by the master), state encoding constants.
- One sub-module: spi_input_sync (parameterised multi-flop synchronizer + rise/fall detect for SCLK), instantiated for cs, sclk, mosi.

Test Plan:
- Memory mem[a]=a[7:0]^8'h5A; READ 03h addr 000010h, 4 bytes -> MISO bytes 4A,4B,48,49; mem_addr sequence 10h,11h,12h,13h(,14h prefetch); oe high only during data.
- 128-bit burst at addr 000470h (master line pattern) -> 16 bytes match mem[470h..47Fh]; first bit sampled on 33rd rise.
- Wrap: READ at FFFFFEh -> bytes mem[FFFFFE], mem[FFFFFF], mem[000000]; mem_addr wraps to 0.
- Command 0Bh -> cmd_err one pulse after 8th rise, no mem_rd, miso=0 through 40 clocks until deselect; next 03h transaction reads correctly.
- Deselect after 20 address bits, and again mid-byte in DATA -> IDLE within SYNC_STAGES+1 clk, miso=0, oe=0; following READ 000000h returns mem[0].
- reset_n low mid-DATA -> all outputs 0 immediately (async); after release with select still high, no data until a fresh select edge and full preamble.

Source files
------------

// File: rtl/spi_rom_responder_pkg.sv
// Shared constants and state encoding for the SPI READ (03h) link.
package spi_rom_responder_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam int unsigned SPI_CMD_LEN  = 8;
    localparam int unsigned SPI_ADDR_LEN = 24;

    // Counter wide enough for the 24 address bits.
    localparam int unsigned BIT_CNT_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for the SPI pins. Lane 0 is SCLK: only its
// rise/fall events leave the block; the remaining lanes leave as levels.
module spi_input_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-2:0] dout,
    output logic             rise_c,
    output logic             fall_c
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic                         prev_q, prev_d;

    // Shift the raw pins through the synchronizer chain.
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1][0];
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout   = sync_q[STAGES-1][WIDTH-1:1];
    assign rise_c = sync_q[STAGES-1][0] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1][0] & prev_q;

endmodule

// File: rtl/spi_rom_responder.sv
// SPI flash-ROM responder: decodes READ (03h) + 24-bit address and streams
// bytes MSB-first on MISO from a byte-wide synchronous memory port.
module spi_rom_responder
    import spi_rom_responder_pkg::*;
#(
    parameter int unsigned MEM_AW         = 24,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          CS_ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [BIT_CNT_W-1:0] CMD_LAST  = BIT_CNT_W'(SPI_CMD_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(SPI_ADDR_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] BYTE_LAST = BIT_CNT_W'(7);

    logic [1:0] pins_s;
    logic       sclk_rise_c, sclk_fall_c;
    logic       cs_s, mosi_s, sel_c;

    spi_input_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({spi_cs, spi_mosi, spi_sclk}),
        .dout    (pins_s),
        .rise_c  (sclk_rise_c),
        .fall_c  (sclk_fall_c)
    );

    assign cs_s   = pins_s[1];
    assign mosi_s = pins_s[0];
    assign sel_c  = CS_ACTIVE_HIGH ? cs_s : ~cs_s;

    state_e                  state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SPI_ADDR_LEN-1:0] in_sr_q, in_sr_d;
    logic [7:0]              out_sr_q, out_sr_d;
    logic [7:0]              prefetch_q, prefetch_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [MEM_AW-1:0]       addr_q, addr_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0]       mem_addr_q, mem_addr_d;
    logic                    miso_q, miso_d;
    logic                    oe_q, oe_d;
    logic                    busy_q, busy_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    armed_q, armed_d;
    logic [SYNC_STAGES:0]    arm_pipe_q, arm_pipe_d;

    logic [SPI_ADDR_LEN-1:0] shifted_c;
    logic [MEM_AW-1:0]       addr_inc_c;

    // Next-state and output logic. A new transaction starts only after
    // deselect has been observed with a full synchronizer pipeline.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        in_sr_d    = in_sr_q;
        out_sr_d   = out_sr_q;
        prefetch_d = prefetch_q;
        rd_pend_d  = mem_rd_q;
        addr_d     = addr_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        cmd_err_d  = 1'b0;
        busy_d     = sel_c;
        arm_pipe_d = {arm_pipe_q[SYNC_STAGES-1:0], 1'b1};
        armed_d    = armed_q | (arm_pipe_q[SYNC_STAGES] & ~sel_c);
        shifted_c  = {in_sr_q[SPI_ADDR_LEN-2:0], mosi_s};
        addr_inc_c = addr_q + MEM_AW'(1);

        if (rd_pend_q) begin
            prefetch_d = mem_data;
        end

        if ((state_q != ST_IDLE) && !sel_c) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            in_sr_d    = '0;
            out_sr_d   = '0;
            prefetch_d = '0;
            rd_pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (armed_q && sel_c) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_c) begin
                        in_sr_d = shifted_c;
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = '0;
                            if (shifted_c[7:0] == SPI_CMD_READ) begin
                                state_d = ST_ADDR;
                            end else begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_c) begin
                        in_sr_d = shifted_c;
                        if (bit_cnt_q == ADDR_LAST) begin
                            bit_cnt_d  = '0;
                            state_d    = ST_DATA;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = shifted_c[MEM_AW-1:0];
                            addr_d     = shifted_c[MEM_AW-1:0];
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall_c) begin
                        if (bit_cnt_q == '0) begin
                            // Load the prefetched byte and fetch the next one.
                            out_sr_d   = prefetch_q;
                            addr_d     = addr_inc_c;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_inc_c;
                        end else begin
                            out_sr_d = {out_sr_q[6:0], 1'b0};
                        end
                        bit_cnt_d = (bit_cnt_q == BYTE_LAST) ? '0
                                                             : bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        miso_d = (state_d == ST_DATA) ? out_sr_d[7] : 1'b0;
        oe_d   = (state_d == ST_DATA);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            in_sr_q    <= '0;
            out_sr_q   <= '0;
            prefetch_q <= '0;
            rd_pend_q  <= 1'b0;
            addr_q     <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            armed_q    <= 1'b0;
            arm_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            in_sr_q    <= in_sr_d;
            out_sr_q   <= out_sr_d;
            prefetch_q <= prefetch_d;
            rd_pend_q  <= rd_pend_d;
            addr_q     <= addr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            cmd_err_q  <= cmd_err_d;
            armed_q    <= armed_d;
            arm_pipe_q <= arm_pipe_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign cmd_err     = cmd_err_q;

endmodule
